and_stream_reducer: RTL
=======================

// Module: and_stream_reducer
// PURPOSE
//   Time-domain counterpart of the spatial AND-reducer: takes a stream of WIDTH-bit words
//   over a valid/ready input, one per accepted beat. Bitwise-ANDs each group of COUNT words.
//   Emits one WIDTH-bit result per group over a valid/ready output.
//   Sits between a word producer and any consumer needing an N-way AND without N parallel buses.
// PARAMETERS
//   WIDTH  4  bits per word and per result
//   COUNT  4  words per group; legal range 1..256
// PORTS
//   CLK         in   1      single clock, rising edge
//   ASYNCRESET  in   1      asynchronous, active-high reset
//   CLR         in   1      synchronous abort of the partial group
//   I           in   WIDTH  input word
//   I_valid     in   1      input word valid
//   I_ready     out  1      reducer can accept I this cycle
//   O           out  WIDTH  group result
//   O_valid     out  1      O holds an unconsumed result
//   O_ready     in   1      consumer accepts O this cycle
// BEHAVIOUR
//   Reset (async, immediate): acc=all-ones, cnt=0, O=0, O_valid=0. I_ready=0 while ASYNCRESET high.
//   Accept event: in_fire = I_valid & I_ready. Output event: out_fire = O_valid & O_ready.
//   Counter: cnt width = max(1, clog2(COUNT)). It counts accepted words within the group, 0..COUNT-1.
//   Non-final accept (cnt<COUNT-1): acc <= acc & I, cnt <= cnt+1.
//   Final accept (cnt==COUNT-1): O <= acc & I, O_valid <= 1, acc <= all-ones, cnt <= 0.
//   Latency: O_valid rises the cycle after the final word is accepted. No combinational I->O path.
//   COUNT==1: every accepted word is the final word. O <= I one cycle after accept.
//   O is stable while O_valid=1 and O_ready=0. It changes only on a new final accept.
//   O_valid clears on out_fire unless a final accept occurs in the same cycle.
//   When both occur, the new result replaces the old with no bubble.
//   I_ready = !ASYNCRESET & !CLR & !(cnt==COUNT-1 & O_valid & !O_ready).
//     Non-final words keep accumulating under output backpressure.
//     Only the final word of a group stalls, and only when the output slot is full and not draining.
//   CLR: acc <= all-ones, cnt <= 0. I_ready is forced 0, so a word offered during CLR is not consumed.
//     CLR does not touch O or O_valid; a pending result survives and drains normally.
//   I_valid=0 cycles: no state change. Gaps within a group are allowed and unbounded.
//   Reset mid-group or with a pending result: both are discarded and the next group starts clean.
//   States implied by (cnt, O_valid): EMPTY(cnt=0,!O_valid), ACCUM(cnt>0), HOLD(O_valid).
//     ACCUM and HOLD may coexist. The implementation uses no separate FSM register.
// STRUCTURE
//   Shared package: cnt-width helper function (max(1,clog2(n))) and the all-ones constant form.
//     These are reused by other stream reducers (or/xor variants).
//   One sub-module: and_stream_out_reg, the valid/ready output holding register.
//     Inputs: load, data, O_ready. Outputs: O, O_valid, a "full & !draining" stall flag.
//   Top level holds acc, cnt, and the I_ready/load logic.
// TESTING (WIDTH=4, COUNT=4 unless noted)
//   1 Basic group: O_ready=1, I=0xF,0xE,0x7,0xD on consecutive beats.
//     Expect O=0x4, O_valid=1 exactly one cycle after the 4th accept, then O_valid=0.
//   2 Backpressure: O_ready=0 after result 0x4.
//     Next group 0xF,0xF,0x3 is accepted; 4th word 0x1 sees I_ready=0.
//     Raise O_ready: 0x4 drains, 0x1 is accepted the same cycle, O=0x1 the next cycle.
//   3 Back-to-back: stream 8 words with O_ready=1 and I_valid=1 continuously.
//     Expect I_ready always 1 and two results one group apart, with no bubble.
//   4 CLR mid-group: accept 0x8,0x8, then CLR with I=0x0 valid (not accepted).
//     Then 0xF x4: expect O=0xF (the cleared 0x8 has no effect).
//   5 Async reset: assert ASYNCRESET mid-cycle with O_valid=1 and cnt=2.
//     O=0, O_valid=0, I_ready=0 immediately. After release, 0x3,0x3,0x3,0x3 gives O=0x3.
//   6 COUNT=1: words 0xA then 0x5 with O_ready=1 give O=0xA then 0x5, each one cycle after its accept.

Source files
------------

// File: rtl/and_stream_reducer_pkg.sv
// Shared helpers for the stream reducer family (and/or/xor variants).
package and_stream_reducer_pkg;

    // Fill bit for an AND accumulator; replicate to the word width.
    localparam logic ACC_FILL = 1'b1;

    // Reset value bit for the output holding register.
    localparam logic OUT_RST_BIT = 1'b0;

    // Group counter width: max(1, clog2(n)), so COUNT==1 still gets a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/and_stream_out_reg.sv
// Valid/ready output holding register. A load always wins over a drain,
// so a new result can replace a consumed one with no bubble.
module and_stream_out_reg
    import and_stream_reducer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             stall_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    // Next-state: load a new result, else clear valid once it is consumed.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load_i) begin
            data_d  = data_i;
            valid_d = 1'b1;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Holding register with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q  <= {WIDTH{OUT_RST_BIT}};
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    // Slot is occupied and the consumer is not taking it this cycle.
    assign stall_o = valid_q & ~ready_i;

endmodule

// File: rtl/and_stream_reducer.sv
// Bitwise-ANDs each group of COUNT accepted words and emits one result per group.
// Only the final word of a group can stall, and only when the output slot is full
// and not draining; earlier words keep accumulating under backpressure.
module and_stream_reducer
    import and_stream_reducer_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int COUNT = 4
) (
    input  logic             CLK,
    input  logic             ASYNCRESET,
    input  logic             CLR,
    input  logic [WIDTH-1:0] I,
    input  logic             I_valid,
    output logic             I_ready,
    output logic [WIDTH-1:0] O,
    output logic             O_valid,
    input  logic             O_ready
);

    localparam int unsigned    CW   = cnt_width(COUNT);
    localparam logic [CW-1:0]  LAST = CW'(COUNT - 1);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_last;
    logic             out_stall;
    logic             in_fire;
    logic             load;

    assign is_last = (cnt_q == LAST);
    assign I_ready = ~ASYNCRESET & ~CLR & ~(is_last & out_stall);
    assign in_fire = I_valid & I_ready;
    assign load    = in_fire & is_last;

    // Next-state for accumulator and in-group word count.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (CLR) begin
            acc_d = {WIDTH{ACC_FILL}};
            cnt_d = '0;
        end else if (in_fire) begin
            if (is_last) begin
                acc_d = {WIDTH{ACC_FILL}};
                cnt_d = '0;
            end else begin
                acc_d = acc_q & I;
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Accumulator and counter registers with asynchronous reset.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            acc_q <= {WIDTH{ACC_FILL}};
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    and_stream_out_reg #(
        .WIDTH (WIDTH)
    ) u_out (
        .clk_i   (CLK),
        .rst_i   (ASYNCRESET),
        .load_i  (load),
        .data_i  (acc_q & I),
        .ready_i (O_ready),
        .data_o  (O),
        .valid_o (O_valid),
        .stall_o (out_stall)
    );

endmodule
